// File: rtl/debug_port_arbiter_pkg.sv
// Owner codes, FSM states and small helpers shared by the debug port arbiter files.
// Latency: none, declarations only.
// Backpressure: not applicable.
package dbg_pkg;

    // Same codes as the top-level debugger type selection
    localparam logic [1:0] OWNER_NONE    = 2'b00;
    localparam logic [1:0] OWNER_DAPLINK = 2'b01;
    localparam logic [1:0] OWNER_JLINK   = 2'b10;
    localparam logic [1:0] OWNER_STLINK  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GUARD = 2'b01,
        ST_OWNED = 2'b10
    } state_t;

    // Activity vector layout: [2]=ST-LINK, [1]=J-LINK, [0]=DAPLINK
    function automatic logic [1:0] prio_winner(input logic [2:0] act);
        logic [1:0] w;
        w = OWNER_NONE;
        if (act[2])      w = OWNER_STLINK;
        else if (act[1]) w = OWNER_JLINK;
        else if (act[0]) w = OWNER_DAPLINK;
        return w;
    endfunction

    // One-hot mask of the activity bit belonging to an owner code
    function automatic logic [2:0] owner_mask(input logic [1:0] code);
        logic [2:0] m;
        case (code)
            OWNER_STLINK:  m = 3'b100;
            OWNER_JLINK:   m = 3'b010;
            OWNER_DAPLINK: m = 3'b001;
            default:       m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/debug_port_arbiter_if.sv
// Probe pin inputs and arbitration result outputs of the debug port arbiter.
// Latency: none, wiring only.
// Backpressure: none; pins are free-running levels, outputs are registered levels/pulses.
interface debug_port_arbiter_if;
    logic [1:0] STLINK_PINS;
    logic [1:0] JLINK_PINS;
    logic [1:0] DAPLINK_PINS;
    logic [1:0] LINK_SEL;
    logic       OWNER_VALID;
    logic       PARK;
    logic       CONTENTION;

    // Probe side / environment
    modport master (
        output STLINK_PINS, JLINK_PINS, DAPLINK_PINS,
        input  LINK_SEL, OWNER_VALID, PARK, CONTENTION
    );

    // Arbiter side
    modport slave (
        input  STLINK_PINS, JLINK_PINS, DAPLINK_PINS,
        output LINK_SEL, OWNER_VALID, PARK, CONTENTION
    );
endinterface

// File: rtl/debug_port_arbiter_act_det.sv
// Synchronises one probe's two raw pins and flags any change between consecutive samples.
// Latency: raw pin change shows on act SYNC_STAGES+1 clocks later, as a one-cycle pulse.
// Backpressure: none; every change produces a pulse regardless of the consumer.
module probe_activity_det #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] RESET_VAL   = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pins,
    output logic       act
);
    logic [1:0] sync_q [SYNC_STAGES];
    logic [1:0] prev_q;

    // Synchroniser chain, previous-sample flop and registered change flag; reset to probe idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VAL;
            prev_q <= RESET_VAL;
            act    <= 1'b0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
            act    <= (sync_q[SYNC_STAGES-1] != prev_q);
        end
    end
endmodule

// File: rtl/debug_port_arbiter.sv
// Grants the shared target debug port to one of three probes, with a parked guard on handover and idle release.
// Latency: pin change to LINK_SEL update SYNC_STAGES+2 clocks; PARK drops GUARD_CYCLES clocks after that.
// Backpressure: none; losing probes are never queued, only flagged on CONTENTION.
module debug_port_arbiter
    import dbg_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 16,
    parameter int TIMEOUT_W    = 24,
    parameter int IDLE_TIMEOUT = 12_000_000
) (
    input  logic CLK,
    input  logic RST,
    debug_port_arbiter_if.slave bus
);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0]        GUARD_LOAD = GW'(GUARD_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] IDLE_LOAD  = TIMEOUT_W'(IDLE_TIMEOUT - 1);

    // Elaboration-time parameter sanity
    if (SYNC_STAGES < 2)  begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");  end
    if (GUARD_CYCLES < 1) begin : g_bad_guard $error("GUARD_CYCLES must be >= 1"); end
    if (IDLE_TIMEOUT < 1 || longint'(IDLE_TIMEOUT) > ((longint'(1) << TIMEOUT_W) - 1)) begin : g_bad_to
        $error("IDLE_TIMEOUT must be >= 1 and fit in TIMEOUT_W bits");
    end

    logic [2:0] act;

    probe_activity_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(2'b11)) u_det_st (
        .clk(CLK), .rst(RST), .pins(bus.STLINK_PINS), .act(act[2]));
    probe_activity_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(2'b11)) u_det_jl (
        .clk(CLK), .rst(RST), .pins(bus.JLINK_PINS), .act(act[1]));
    probe_activity_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(2'b11)) u_det_dap (
        .clk(CLK), .rst(RST), .pins(bus.DAPLINK_PINS), .act(act[0]));

    state_t                 state;
    logic [1:0]             link_sel;
    logic                   owner_valid;
    logic                   park;
    logic                   contention;
    logic [GW-1:0]          guard_cnt;
    logic [TIMEOUT_W-1:0]   idle_cnt;

    logic [1:0] winner;
    logic       owner_act;
    logic       loser_busy;
    logic       loser_arb;

    // Winner of a fresh arbitration, and owner/non-owner activity split against the held owner
    always_comb begin
        winner     = prio_winner(act);
        owner_act  = |(act & owner_mask(link_sel));
        loser_busy = |(act & ~owner_mask(link_sel));
        loser_arb  = |(act & ~owner_mask(winner));
    end

    // Ownership FSM; LINK_SEL only changes on IDLE->GUARD so the analog switch settles while parked
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            link_sel    <= OWNER_NONE;
            owner_valid <= 1'b0;
            park        <= 1'b1;
            contention  <= 1'b0;
            guard_cnt   <= '0;
            idle_cnt    <= '0;
        end else begin
            contention <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|act) begin
                        state      <= ST_GUARD;
                        link_sel   <= winner;
                        guard_cnt  <= GUARD_LOAD;
                        contention <= loser_arb;
                    end
                end
                ST_GUARD: begin
                    contention <= loser_busy;
                    if (guard_cnt == '0) begin
                        state       <= ST_OWNED;
                        idle_cnt    <= IDLE_LOAD;
                        park        <= 1'b0;
                        owner_valid <= 1'b1;
                    end else begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                end
                ST_OWNED: begin
                    contention <= loser_busy;
                    if (owner_act) begin
                        idle_cnt <= IDLE_LOAD;
                    end else if (idle_cnt == '0) begin
                        state       <= ST_IDLE;
                        park        <= 1'b1;
                        owner_valid <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt - TIMEOUT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.LINK_SEL    = link_sel;
    assign bus.OWNER_VALID = owner_valid;
    assign bus.PARK        = park;
    assign bus.CONTENTION  = contention;

endmodule

// File: tb/tb_debug_port_arbiter.sv
// Bench for debug_port_arbiter: directed scenarios plus random pin/reset traffic against a timestamp model.
// Latency: model predicts outputs per clock edge; monitor compares on the following falling edge.
// Backpressure: not applicable.
module tb_debug_port_arbiter;
    localparam int S  = 2;
    localparam int G  = 4;
    localparam int IT = 20;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    debug_port_arbiter_if bus();

    debug_port_arbiter #(
        .SYNC_STAGES(S), .GUARD_CYCLES(G), .TIMEOUT_W(8), .IDLE_TIMEOUT(IT)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    typedef struct packed {
        logic [1:0] link;
        logic       ov;
        logic       park;
        logic       cont;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: synchroniser is a pure delay over a pin history; ownership tracked by timestamps
    logic [5:0] hist[$];
    bit         busy;
    logic [1:0] m_owner;
    bit         m_cont;
    longint     k = 0;
    longint     t_own;
    longint     t_ref;
    logic [2:0] m_act;
    int         m_idx;
    exp_t       m_exp;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 3; i++) hist.push_back(6'h3F);
        busy    = 1'b0;
        m_owner = 2'b00;
        m_cont  = 1'b0;
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            model_reset();
        end else begin
            k++;
            hist.push_back({bus.STLINK_PINS, bus.JLINK_PINS, bus.DAPLINK_PINS});
            void'(hist.pop_front());
            // activity seen at this edge reflects pin samples S+1 and S+2 edges ago
            m_act[2] = (hist[1][5:4] != hist[0][5:4]);
            m_act[1] = (hist[1][3:2] != hist[0][3:2]);
            m_act[0] = (hist[1][1:0] != hist[0][1:0]);
            if (!busy) begin
                if (m_act != 3'b000) begin
                    m_owner = m_act[2] ? 2'b11 : (m_act[1] ? 2'b10 : 2'b01);
                    m_idx   = int'(m_owner) - 1;
                    m_cont  = (m_act & ~(3'b001 << m_idx)) != 3'b000;
                    busy    = 1'b1;
                    t_own   = k + G;
                    t_ref   = t_own;
                end else begin
                    m_cont = 1'b0;
                end
            end else begin
                m_idx  = int'(m_owner) - 1;
                m_cont = (m_act & ~(3'b001 << m_idx)) != 3'b000;
                if (k > t_own) begin
                    if (m_act[m_idx]) t_ref = k;
                    else if (k - t_ref >= IT) busy = 1'b0;
                end
            end
            m_exp.link = m_owner;
            m_exp.ov   = busy && (k >= t_own);
            m_exp.park = !m_exp.ov;
            m_exp.cont = m_cont;
            sb_q.push_back(m_exp);
        end
    end

    // Monitor: one expected entry per clock edge, compared away from the edge
    exp_t got_e;
    exp_t want_e;
    always @(negedge CLK) begin
        if (!RST && sb_q.size() > 0) begin
            want_e = sb_q.pop_front();
            got_e  = {bus.LINK_SEL, bus.OWNER_VALID, bus.PARK, bus.CONTENTION};
            total++;
            if (got_e !== want_e) begin
                bad++;
                $display("FAIL cycle_check t=%0t got link=%b ov=%b park=%b cont=%b want link=%b ov=%b park=%b cont=%b",
                         $time, got_e.link, got_e.ov, got_e.park, got_e.cont,
                         want_e.link, want_e.ov, want_e.park, want_e.cont);
            end
        end
    end

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got {link,ov,park,cont}=%b want %b", name, $time, got, want);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.LINK_SEL, bus.OWNER_VALID, bus.PARK, bus.CONTENTION};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tog(input int probe, input int b);
        case (probe)
            2:       bus.STLINK_PINS[b]  = ~bus.STLINK_PINS[b];
            1:       bus.JLINK_PINS[b]   = ~bus.JLINK_PINS[b];
            default: bus.DAPLINK_PINS[b] = ~bus.DAPLINK_PINS[b];
        endcase
    endtask

    // Assert reset off-edge and verify outputs fall to reset values without waiting for a clock
    task automatic async_reset(input string name);
        RST = 1'b1;
        sb_q.delete();
        #1;
        check(name, outs(), 5'b00_0_1_0);
    endtask

    initial begin
        RST = 1'b0;
        bus.STLINK_PINS  = 2'b11;
        bus.JLINK_PINS   = 2'b11;
        bus.DAPLINK_PINS = 2'b11;
        #2;
        RST = 1'b1;
        #1;
        check("reset_values", outs(), 5'b00_0_1_0);
        cyc(3);
        RST = 1'b0;

        // 1: quiet probes after reset
        cyc(100);
        check("idle_after_quiet", outs(), 5'b00_0_1_0);

        // 2: single J-LINK toggle, exact grant and guard timing
        @(negedge CLK);
        tog(1, 0);
        repeat (S + 1) @(posedge CLK);
        #1 check("jl_before_grant", outs(), 5'b00_0_1_0);
        @(posedge CLK);
        #1 check("jl_grant_edge", outs(), 5'b10_0_1_0);
        repeat (G - 1) @(posedge CLK);
        #1 check("jl_guard_last", outs(), 5'b10_0_1_0);
        @(posedge CLK);
        #1 check("jl_owned", outs(), 5'b10_1_0_0);
        cyc(IT + 5);
        check("jl_released_held", outs(), 5'b10_0_1_0);

        // 3: all three probes toggle together
        @(negedge CLK);
        tog(2, 0); tog(1, 1); tog(0, 0);
        cyc(10);
        check("all_st_wins", outs(), 5'b11_1_0_0);
        cyc(IT + 10);

        // 4: DAPLINK owns while ST-LINK keeps toggling
        @(negedge CLK);
        tog(0, 1);
        cyc(10);
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (i % 3 == 0)  tog(2, 0);
            if (i % 10 == 9) tog(0, 0);
        end
        check("dap_keeps_port", outs() & 5'b11_1_1_0, 5'b01_1_0_0);
        cyc(IT + 10);

        // 5: owner activity every 10 cycles holds the port; silence releases it
        @(negedge CLK);
        tog(2, 1);
        cyc(10);
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (i % 10 == 0) tog(2, 1);
        end
        check("st_held_by_activity", outs(), 5'b11_1_0_0);
        cyc(IT + 10);
        check("st_released", outs(), 5'b11_0_1_0);

        // 6: reset in the middle of GUARD, off-edge, then re-arbitration
        @(negedge CLK);
        tog(1, 0);
        repeat (S + 3) @(posedge CLK);
        #3;
        async_reset("reset_mid_guard");
        cyc(2);
        RST = 1'b0;
        cyc(40);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            for (int p = 0; p < 3; p++)
                for (int b = 0; b < 2; b++)
                    if ($urandom_range(0, 29) == 0) tog(p, b);
            if ($urandom_range(0, 999) == 0) begin
                #($urandom_range(1, 3));
                async_reset("reset_random");
                cyc(2);
                RST = 1'b0;
            end
        end

        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
